// File: rtl/piso_pkg.sv
// piso_pkg: types and helpers shared by the piso_tx transmitter.
//   piso_state_t   - transmitter FSM state encoding (2 bits)
//   piso_cnt_width - width of the bit counter for a given word width
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_t;

  // Counter width needed to count 0..w-1. The result is never below 1, so a
  // counter always exists even for the narrowest word.
  function automatic int piso_cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: bit-position counter for the transmitter.
//   clk         - clock, rising edge
//   clr         - asynchronous active-high clear
//   load_zero_i - synchronous clear to 0 (start of a word)
//   en_i        - increment by one
//   cnt_o       - current count
//   last_o      - high while count == WIDTH-1
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH,
  parameter int CW    = piso_cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load_zero_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_zero_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
// Accepts one WIDTH-bit word over a valid/ready handshake, then drives it out
// one bit per shift_en cycle on sout, followed by a one-cycle done pulse.
//   clk        - clock, rising edge
//   clr        - asynchronous active-high reset
//   din        - parallel word to send
//   load_valid - din is valid
//   load_ready - block can accept a word (low while clr is high)
//   shift_en   - bit-rate enable; current bit is consumed when high
//   sout       - serial data (IDLE_LEVEL when no data bit is on the line)
//   sout_valid - sout carries a data bit
//   first      - sout carries the first bit of a word
//   done       - one-cycle pulse after the last bit is consumed
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = PISO_DEFAULT_WIDTH,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             first,
  output logic             done
);

  localparam int CW = piso_cnt_width(WIDTH);

  piso_state_t      state_q;
  piso_state_t      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  logic             cnt_load_zero;
  logic             cnt_en;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             cur_bit;

  piso_bit_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_cnt (
    .clk         (clk),
    .clr         (clr),
    .load_zero_i (cnt_load_zero),
    .en_i        (cnt_en),
    .cnt_o       (cnt),
    .last_o      (cnt_last)
  );

  // The bit on the line always sits at the output end of the register.
  assign cur_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

  // Next-state, datapath control and output decode.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_load_zero = 1'b0;
    cnt_en        = 1'b0;
    load_ready    = 1'b0;
    sout          = IDLE_LEVEL;
    sout_valid    = 1'b0;
    first         = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      IDLE: begin
        // clr gates load_ready so the handshake is closed during reset.
        load_ready = ~clr;
        // shift_en is deliberately ignored here; a load always wins.
        if (load_valid) begin
          shreg_d       = din;
          cnt_load_zero = 1'b1;
          state_d       = SHIFT;
        end
      end

      SHIFT: begin
        sout       = cur_bit;
        sout_valid = 1'b1;
        first      = (cnt == '0);
        if (shift_en) begin
          // Zeros enter the vacated end; they are never transmitted.
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          if (cnt_last) begin
            // Counter parks at WIDTH-1 so it never wraps.
            state_d = DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

endmodule
